// File: rtl/string_printer_pkg.sv
// Shared types and constants for the string printer: FSM states, the NUL
// terminator and the big-endian byte-lane numbering.
package string_printer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } sp_state_t;

    localparam logic [7:0] SP_NUL      = 8'h00;
    localparam logic [1:0] SP_LANE_MSB = 2'd0;
    localparam logic [1:0] SP_LANE_LSB = 2'd3;

endpackage

// File: rtl/string_printer_byte_lane_sel.sv
// Picks one byte out of a 32-bit word; lane 0 is the most significant byte
// so a string stored big-endian reads out in address order.
module byte_lane_sel
    import string_printer_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = word[31:24];
        case (off)
            SP_LANE_MSB: byte_o = word[31:24];
            2'd1:        byte_o = word[23:16];
            2'd2:        byte_o = word[15:8];
            SP_LANE_LSB: byte_o = word[7:0];
            default:     byte_o = word[31:24];
        endcase
    end

endmodule

// File: rtl/string_printer.sv
// Walks a NUL-terminated string in data memory and streams it one character
// per handshake. Define STRING_PRINTER_SIM_EN to echo characters to the console.
module string_printer
    import string_printer_pkg::*;
#(
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] str_addr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        truncated
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    sp_state_t     state_q, state_d;
    logic [29:0]   word_addr_q, word_addr_d;
    logic [1:0]    byte_off_q, byte_off_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   word_buf_q, word_buf_d;
    logic          trunc_q, trunc_d;
    logic [7:0]    cur_byte;
    logic [CW-1:0] cnt_inc;

    byte_lane_sel u_lane (
        .word   (word_buf_q),
        .off    (byte_off_q),
        .byte_o (cur_byte)
    );

    assign cnt_inc = count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        byte_off_d  = byte_off_q;
        count_d     = count_q;
        word_buf_d  = word_buf_q;
        trunc_d     = trunc_q;
        case (state_q)
            IDLE: begin
                if (str_addr != 32'd0) begin
                    word_addr_d = str_addr[31:2];
                    byte_off_d  = str_addr[1:0];
                    count_d     = '0;
                    trunc_d     = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    word_buf_d = mem_rdata;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (cur_byte == SP_NUL) begin
                    trunc_d = 1'b0;
                    state_d = DONE;
                end else if (char_ready) begin
                    count_d = cnt_inc;
                    // Length limit outranks the word boundary: no extra read.
                    if (cnt_inc == MAX_CNT) begin
                        trunc_d = 1'b1;
                        state_d = DONE;
                    end else if (byte_off_q == SP_LANE_LSB) begin
                        byte_off_d  = SP_LANE_MSB;
                        word_addr_d = word_addr_q + 30'd1;
                        state_d     = FETCH;
                    end else begin
                        byte_off_d = byte_off_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            byte_off_q  <= '0;
            count_q     <= '0;
            word_buf_q  <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            byte_off_q  <= byte_off_d;
            count_q     <= count_d;
            word_buf_q  <= word_buf_d;
            trunc_q     <= trunc_d;
        end
    end

    // Outputs decode only from registered state, so handshake inputs never
    // reach an output combinationally.
    assign mem_rd     = (state_q == FETCH);
    assign mem_addr   = mem_rd ? {word_addr_q, 2'b00} : 32'd0;
    assign char_valid = (state_q == EMIT) && (cur_byte != SP_NUL);
    assign char_data  = char_valid ? cur_byte : 8'd0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign truncated  = done && trunc_q;

`ifdef STRING_PRINTER_SIM_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (char_valid && char_ready)
                $write("%c", char_data);
            if (done && truncated)
                $display("string_printer: warning, string truncated at %0d characters", MAX_LEN);
        end
    end
`endif

endmodule

// File: tb/tb_string_printer.sv
// Bench for string_printer: directed timing/reset/stall steps, then random
// strings checked against a byte-walk reference model.
`timescale 1ns/1ps
module tb_string_printer;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] str_addr;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        truncated;

    always #5 clk = ~clk;

    string_printer #(.MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .reset      (reset),
        .str_addr   (str_addr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .truncated  (truncated)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [int unsigned];
    int mem_mode = 0;   // 0 zero-wait, 1 random wait, 2 never ready
    int snk_mode = 0;   // 0 always ready, 1 random, 2 never ready

    logic [7:0]  got_chars [$];
    logic [31:0] got_reads [$];
    int          done_cnt = 0;
    logic        last_trunc = 1'b0;

    logic [7:0]  exp_chars [$];
    logic [31:0] exp_reads [$];
    logic        exp_trunc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return mem.exists(k) ? mem[k] : 32'd0;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w = mem_word(a);
        int lane = int'(a[1:0]);
        logic [31:0] s = w >> (8 * (3 - lane));
        return s[7:0];
    endfunction

    function automatic void set_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w = mem_word(a);
        int lane = int'(a[1:0]);
        w[8*(3-lane) +: 8] = b;
        mem[int'(a >> 2)] = w;
    endfunction

    // Reference: walk bytes from the start address; every byte examined
    // (characters plus a found NUL) lives in a word that must be read once.
    function automatic void model(input logic [31:0] start);
        logic [31:0] a = start;
        logic [31:0] w;
        logic [7:0]  b;
        int n = 0;
        exp_chars.delete();
        exp_reads.delete();
        exp_trunc = 1'b0;
        forever begin
            w = {a[31:2], 2'b00};
            if (exp_reads.size() == 0 || exp_reads[$] != w)
                exp_reads.push_back(w);
            b = byte_at(a);
            if (b == 8'd0) break;
            exp_chars.push_back(b);
            n++;
            if (n == MAXL) begin
                exp_trunc = 1'b1;
                break;
            end
            a = a + 32'd1;
        end
    endfunction

    function automatic void clear_obs();
        got_chars.delete();
        got_reads.delete();
        done_cnt = 0;
    endfunction

    // Drives memory/sink at negedge, then samples all handshakes 1ns later.
    initial begin
        logic       pend = 1'b0;
        logic [7:0] pend_data = 8'd0;
        mem_ready  = 1'b0;
        char_ready = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            case (mem_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 2) != 0);
                default: mem_ready = 1'b0;
            endcase
            case (snk_mode)
                0:       char_ready = 1'b1;
                1:       char_ready = ($urandom_range(0, 2) != 0);
                default: char_ready = 1'b0;
            endcase
            mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hDEADBEEF;
            #1;
            if (pend) begin
                chk("hold_valid", {31'd0, char_valid}, 32'd1);
                chk("hold_data", {24'd0, char_data}, {24'd0, pend_data});
            end
            if (!reset) begin
                if (mem_rd && mem_ready) got_reads.push_back(mem_addr);
                if (char_valid && char_ready) got_chars.push_back(char_data);
                if (done) begin
                    done_cnt++;
                    last_trunc = truncated;
                end
            end
            pend = !reset && char_valid && !char_ready;
            pend_data = char_data;
        end
    end

    task automatic finish_check(input string tag);
        int cyc = 0;
        int n;
        while (done_cnt == 0 && cyc < 400) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_trunc"}, {31'd0, last_trunc}, {31'd0, exp_trunc});
        chk({tag, "_nchars"}, got_chars.size(), exp_chars.size());
        n = (got_chars.size() < exp_chars.size()) ? got_chars.size() : exp_chars.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_char"}, {24'd0, got_chars[i]}, {24'd0, exp_chars[i]});
        chk({tag, "_nreads"}, got_reads.size(), exp_reads.size());
        n = (got_reads.size() < exp_reads.size()) ? got_reads.size() : exp_reads.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_read"}, got_reads[i], exp_reads[i]);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        $display("[TB] %s addr_reads=%0d chars=%0d truncated=%0b", tag, got_reads.size(), got_chars.size(), last_trunc);
    endtask

    task automatic run(input logic [31:0] a, input string tag);
        model(a);
        clear_obs();
        str_addr = a;
        @(negedge clk);
        str_addr = 32'd0;
        finish_check(tag);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_memrd"}, {31'd0, mem_rd}, 32'd0);
        chk({tag, "_memaddr"}, mem_addr, 32'd0);
        chk({tag, "_cvalid"}, {31'd0, char_valid}, 32'd0);
        chk({tag, "_cdata"}, {24'd0, char_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_trunc"}, {31'd0, truncated}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int len;
        reset    = 1'b1;
        str_addr = 32'd0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;
        @(negedge clk);

        // "Hi" with exact cycle timing
        mem.delete();
        mem[32'h100 >> 2] = 32'h48690000;
        clear_obs();
        str_addr = 32'h100;
        @(negedge clk);
        str_addr = 32'd0;
        chk("hi_fetch_rd", {31'd0, mem_rd}, 32'd1);
        chk("hi_fetch_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("hi_h_valid", {31'd0, char_valid}, 32'd1);
        chk("hi_h_data", {24'd0, char_data}, 32'h48);
        @(negedge clk);
        chk("hi_i_valid", {31'd0, char_valid}, 32'd1);
        chk("hi_i_data", {24'd0, char_data}, 32'h69);
        @(negedge clk);
        chk("hi_nul_valid", {31'd0, char_valid}, 32'd0);
        chk("hi_nul_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("hi_done", {31'd0, done}, 32'd1);
        chk("hi_done_trunc", {31'd0, truncated}, 32'd0);
        @(negedge clk);
        chk("hi_idle_busy", {31'd0, busy}, 32'd0);
        chk("hi_idle_done", {31'd0, done}, 32'd0);
        $display("[TB] hi_timing chars=%0d", got_chars.size());

        // Unaligned start crossing a word boundary
        mem.delete();
        mem[32'h200 >> 2] = 32'hAAAAAA41;
        mem[32'h204 >> 2] = 32'h42000000;
        run(32'h203, "unaligned");

        // Sink stalls on the first character
        mem.delete();
        mem[32'h100 >> 2] = 32'h48690000;
        model(32'h100);
        clear_obs();
        snk_mode = 2;
        @(negedge clk);
        str_addr = 32'h100;
        @(negedge clk);
        str_addr = 32'd0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, char_valid}, 32'd1);
            chk("stall_data", {24'd0, char_data}, 32'h48);
            @(negedge clk);
        end
        snk_mode = 0;
        finish_check("stall");

        // No NUL: stops at MAX_LEN with a single read
        mem.delete();
        for (int i = 0; i < 4; i++) mem[(32'h300 >> 2) + i] = 32'h41414141;
        run(32'h300, "maxlen");

        // Word address wraps from the top of memory to zero
        mem.delete();
        set_byte(32'hFFFFFFFE, 8'h78);
        set_byte(32'hFFFFFFFF, 8'h79);
        set_byte(32'h00000000, 8'h7A);
        set_byte(32'h00000001, 8'h00);
        run(32'hFFFFFFFE, "wrap");

        // Reset during a stalled FETCH, then during a held EMIT
        mem.delete();
        mem[32'h100 >> 2] = 32'h48690000;
        mem_mode = 2;
        @(negedge clk);
        str_addr = 32'h100;
        @(negedge clk);
        str_addr = 32'd0;
        @(negedge clk);
        chk("rstf_pre_rd", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("rst_fetch");
        reset = 1'b0;
        mem_mode = 0;
        snk_mode = 2;
        @(negedge clk);
        str_addr = 32'h100;
        @(negedge clk);
        str_addr = 32'd0;
        @(negedge clk);
        chk("rste_pre_valid", {31'd0, char_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("rst_emit");
        reset = 1'b0;
        snk_mode = 0;
        @(negedge clk);
        run(32'h100, "after_reset");

        // A second request while busy is ignored
        mem.delete();
        mem[32'h100 >> 2] = 32'h48690000;
        mem[32'h400 >> 2] = 32'h5A000000;
        model(32'h100);
        clear_obs();
        str_addr = 32'h100;
        @(negedge clk);
        str_addr = 32'h400;
        repeat (2) @(negedge clk);
        str_addr = 32'd0;
        finish_check("second_req");

        // Random strings, addresses and handshake stalls
        for (int t = 0; t < 40; t++) begin
            mem.delete();
            a = $urandom;
            if (a == 32'd0) a = 32'd4;
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++)
                set_byte(a + i, 8'($urandom_range(1, 255)));
            if ($urandom_range(0, 3) != 0)
                set_byte(a + len, 8'h00);
            else
                set_byte(a + len, 8'($urandom_range(1, 255)));
            mem_mode = $urandom_range(0, 1);
            snk_mode = $urandom_range(0, 1);
            run(a, "rand");
        end
        mem_mode = 0;
        snk_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
